// File: rtl/gen1_descramble.sv
// Gen1/Gen2 receive descrambler: removes the x^16+x^5+x^4+x^3+1 scrambling on
// 1, 2 or 4 symbols per beat, with COM resync, SKP hold and TS ordered-set bypass.

module byte_scramble (
  input  logic [15:0] lfsr_in,
  input  logic [7:0]  data_in,
  input  logic        disable_scrambling,
  output logic [7:0]  data_out,
  output logic [15:0] lfsr_out
);
  logic [7:0] mask;

  // Bit i of a byte meets LFSR[15] after i shifts, which is the untouched LFSR[15-i].
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      mask[b] = lfsr_in[15-b];
    end
  end

  always_comb begin
    logic [15:0] state;
    state = lfsr_in;
    for (int s = 0; s < 8; s++) begin
      state = {state[14:0], state[15]} ^ (state[15] ? 16'h0038 : 16'h0000);
    end
    lfsr_out = state;
  end

  assign data_out = disable_scrambling ? data_in : (data_in ^ mask);
endmodule

module gen1_descramble #(
  parameter logic [15:0] LFSR_SEED     = 16'hFFFF,
  parameter int          TS_BYPASS_LEN = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_in_i,
  input  logic [3:0]  data_k_in_i,
  input  logic        data_valid_i,
  input  logic [5:0]  pipe_width_i,
  input  logic        disable_scrambling_i,
  output logic [31:0] data_out_o,
  output logic [3:0]  data_k_out_o,
  output logic        data_valid_o,
  output logic        locked_o
);
  localparam int TS_W = $clog2(TS_BYPASS_LEN + 1);

  logic [15:0]     lfsr_reg;
  logic [TS_W-1:0] ts_cnt_reg;
  logic            after_com_reg;
  logic            locked_reg;
  logic [31:0]     data_out_reg;
  logic [3:0]      data_k_reg;
  logic            data_valid_reg;

  logic [31:0] data_next;
  logic [3:0]  data_k_next;
  logic [5:0]  n_bytes;

  assign n_bytes = pipe_width_i >> 3;

  // State ripples byte to byte, so a COM or TS window start in one lane
  // governs the later lanes of the same beat.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    logic [15:0]     lfsr_cur, lfsr_next, lfsr_adv;
    logic [TS_W-1:0] ts_cur, ts_next;
    logic            after_cur, after_next;
    logic            lock_cur, lock_next;
    logic [7:0]      sym, scr, dout;
    logic            is_k, is_com, is_skp, is_pad, active, bypass, kout;

    if (gi == 0) begin : g_first
      assign lfsr_cur  = lfsr_reg;
      assign ts_cur    = ts_cnt_reg;
      assign after_cur = after_com_reg;
      assign lock_cur  = locked_reg;
    end else begin : g_rest
      assign lfsr_cur  = g_byte[gi-1].lfsr_next;
      assign ts_cur    = g_byte[gi-1].ts_next;
      assign after_cur = g_byte[gi-1].after_next;
      assign lock_cur  = g_byte[gi-1].lock_next;
    end

    assign sym    = data_in_i[8*gi +: 8];
    assign is_k   = data_k_in_i[gi];
    assign is_com = is_k && (sym == 8'hBC);
    assign is_skp = is_k && (sym == 8'h1C);
    assign is_pad = is_k && (sym == 8'hF7);
    assign active = n_bytes > 6'(gi);

    byte_scramble u_scr (
      .lfsr_in            (lfsr_cur),
      .data_in            (sym),
      .disable_scrambling (1'b0),
      .data_out           (scr),
      .lfsr_out           (lfsr_adv)
    );

    always_comb begin
      lfsr_next  = lfsr_cur;
      ts_next    = ts_cur;
      after_next = after_cur;
      lock_next  = lock_cur;
      dout       = 8'h00;
      kout       = 1'b0;
      bypass     = 1'b0;
      if (active) begin
        dout = sym;
        kout = is_k;
        if (is_com) begin
          lfsr_next  = LFSR_SEED;
          ts_next    = '0;
          after_next = 1'b1;
          lock_next  = 1'b1;
        end else begin
          if (!is_skp) begin
            lfsr_next = lfsr_adv;
          end
          // The symbol right after COM is itself the first bypassed one of a TS.
          if (after_cur) begin
            after_next = 1'b0;
            bypass     = 1'b1;
            ts_next    = (!is_k || is_pad) ? TS_W'(TS_BYPASS_LEN - 1) : '0;
          end else if (!is_skp && (ts_cur != '0)) begin
            bypass  = 1'b1;
            ts_next = ts_cur - TS_W'(1);
          end
          if (!is_k && !bypass && lock_cur && !disable_scrambling_i) begin
            dout = scr;
          end
        end
      end
    end

    assign data_next[8*gi +: 8] = dout;
    assign data_k_next[gi]      = kout;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_reg       <= LFSR_SEED;
      ts_cnt_reg     <= '0;
      after_com_reg  <= 1'b0;
      locked_reg     <= 1'b0;
      data_out_reg   <= '0;
      data_k_reg     <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      data_valid_reg <= data_valid_i;
      if (data_valid_i) begin
        lfsr_reg      <= g_byte[3].lfsr_next;
        ts_cnt_reg    <= g_byte[3].ts_next;
        after_com_reg <= g_byte[3].after_next;
        locked_reg    <= g_byte[3].lock_next;
        data_out_reg  <= data_next;
        data_k_reg    <= data_k_next;
      end
    end
  end

  assign data_out_o   = data_out_reg;
  assign data_k_out_o = data_k_reg;
  assign data_valid_o = data_valid_reg;
  assign locked_o     = locked_reg;
endmodule

// File: tb/tb_gen1_descramble.sv
// Bench for gen1_descramble: directed sequences with literal expectations plus
// randomized beats checked every cycle against a symbol-serial reference model.

module tb_gen1_descramble;
  localparam logic [15:0] SEED   = 16'hFFFF;
  localparam int          TS_LEN = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [3:0]  k_in;
  logic        valid;
  logic [5:0]  width;
  logic        dis;
  logic [31:0] data_out;
  logic [3:0]  k_out;
  logic        valid_out;
  logic        locked;

  int total = 0;
  int bad   = 0;

  gen1_descramble #(.LFSR_SEED(SEED), .TS_BYPASS_LEN(TS_LEN)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .data_in_i            (data_in),
    .data_k_in_i          (k_in),
    .data_valid_i         (valid),
    .pipe_width_i         (width),
    .disable_scrambling_i (dis),
    .data_out_o           (data_out),
    .data_k_out_o         (k_out),
    .data_valid_o         (valid_out),
    .locked_o             (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference scrambler, one bit at a time: emit LFSR[15], then clock the
  // polynomial x^16+x^5+x^4+x^3+1 once. Returns {lfsr after 8 bits, mask}.
  function automatic logic [23:0] scr8(input logic [15:0] l);
    logic [7:0] m;
    logic fb;
    for (int i = 0; i < 8; i++) begin
      m[i] = l[15];
      fb   = l[15];
      l    = l << 1;
      l[0] = fb;
      l[3] = l[3] ^ fb;
      l[4] = l[4] ^ fb;
      l[5] = l[5] ^ fb;
    end
    return {l, m};
  endfunction

  logic [15:0] m_lfsr;
  int          m_ts;
  bit          m_after, m_locked;
  logic [31:0] exp_data;
  logic [3:0]  exp_k;
  logic        exp_valid;

  function automatic logic [7:0] model_sym(input logic [7:0] s, input logic k);
    logic [23:0] r;
    bit byp;
    byp = 0;
    if (k && s == 8'hBC) begin
      m_lfsr = SEED; m_after = 1; m_locked = 1; m_ts = 0;
      return s;
    end
    r = scr8(m_lfsr);
    if (m_after) begin
      m_after = 0;
      m_ts = (!k || s == 8'hF7) ? TS_LEN : 0;
    end
    if (!(k && s == 8'h1C)) begin
      if (m_ts > 0) begin
        byp = 1;
        m_ts--;
      end
      m_lfsr = r[23:8];
    end
    return (!k && !byp && m_locked && !dis) ? (s ^ r[7:0]) : s;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_lfsr = SEED; m_ts = 0; m_after = 0; m_locked = 0;
      exp_data = '0; exp_k = '0; exp_valid = 1'b0;
    end else begin
      exp_valid = valid;
      if (valid) begin
        for (int b = 0; b < 4; b++) begin
          if (b < int'(width) / 8) begin
            exp_data[8*b +: 8] = model_sym(data_in[8*b +: 8], k_in[b]);
            exp_k[b]           = k_in[b];
          end else begin
            exp_data[8*b +: 8] = 8'h00;
            exp_k[b]           = 1'b0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cyc_valid", {31'b0, valid_out}, {31'b0, exp_valid});
    chk("cyc_data", data_out, exp_data);
    chk("cyc_k", {28'b0, k_out}, {28'b0, exp_k});
    chk("cyc_locked", {31'b0, locked}, {31'b0, m_locked});
  end

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic v);
    data_in = d; k_in = k; valid = v;
    @(negedge clk);
    $display("beat rst=%b w=%0d d=%h k=%b v=%b -> out=%h k=%b v=%b lock=%b",
             rst, width, d, k, v, data_out, k_out, valid_out, locked);
  endtask

  initial begin
    logic [23:0] r;
    logic [15:0] l;
    rst = 1'b1; valid = 1'b0; data_in = '0; k_in = '0; width = 6'd32; dis = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", data_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_locked", {31'b0, locked}, 32'h0);
    rst = 1'b0;

    // Data before any COM passes through
    beat(32'h12345678, 4'b0000, 1'b1);
    chk("precom_data", data_out, 32'h12345678);
    chk("precom_locked", {31'b0, locked}, 32'h0);

    // COM, SKP, then the seed sequence FF 17 C0 14 descrambles to zero
    beat(32'h17FF1CBC, 4'b0011, 1'b1);
    chk("com_beat", data_out, 32'h00001CBC);
    chk("com_k", {28'b0, k_out}, 32'h3);
    chk("lock_after_com", {31'b0, locked}, 32'h1);
    beat(32'hAAAA14C0, 4'b0000, 1'b1);
    chk("seq_c0_14", {16'h0, data_out[15:0]}, 32'h0);
    beat(32'h0, 4'b0000, 1'b0);
    chk("idle_valid", {31'b0, valid_out}, 32'h0);

    // SKP between FF and 17 holds the LFSR
    beat(32'h1CFF1CBC, 4'b1011, 1'b1);
    chk("skp_mid", data_out, 32'h1C001CBC);
    chk("skp_mid_k", {28'b0, k_out}, 32'hB);
    beat(32'h0014C017, 4'b0000, 1'b1);
    chk("after_skp", {8'h0, data_out[23:0]}, 32'h0);

    // TS1: COM, PAD, 14 x 4A bypassed, then FF with the LFSR 15 bytes from seed
    beat(32'h4A4AF7BC, 4'b0011, 1'b1);
    chk("ts_beat0", data_out, 32'h4A4AF7BC);
    for (int i = 0; i < 3; i++) begin
      beat(32'h4A4A4A4A, 4'b0000, 1'b1);
      chk("ts_body", data_out, 32'h4A4A4A4A);
    end
    l = SEED;
    for (int i = 0; i < 15; i++) begin
      r = scr8(l);
      l = r[23:8];
    end
    r = scr8(l);
    beat(32'h000000FF, 4'b0000, 1'b1);
    chk("ts_after", {24'h0, data_out[7:0]}, {24'h0, 8'hFF ^ r[7:0]});

    // Width 8: upper lanes carry COMs that must be ignored
    beat(32'h0, 4'b0000, 1'b0);
    width = 6'd8;
    beat(32'hBCBCBCBC, 4'b1111, 1'b1);
    chk("w8_com", data_out, 32'h000000BC);
    chk("w8_com_k", {28'b0, k_out}, 32'h1);
    beat(32'hBCBCBC1C, 4'b1111, 1'b1);
    chk("w8_skp", data_out, 32'h0000001C);
    beat(32'hBCBCBCFF, 4'b1110, 1'b1);
    chk("w8_ff", data_out, 32'h0);
    beat(32'h12345617, 4'b0000, 1'b1);
    chk("w8_17", data_out, 32'h0);
    beat(32'h0, 4'b0000, 1'b0);
    width = 6'd32;

    // Scrambling disabled: everything passes through
    dis = 1'b1;
    beat(32'h17FF1CBC, 4'b0011, 1'b1);
    chk("dis_com", data_out, 32'h17FF1CBC);
    beat(32'h12345678, 4'b0000, 1'b1);
    chk("dis_data", data_out, 32'h12345678);
    dis = 1'b0;

    // Reset inside a TS window, then a fresh COM decodes from seed
    beat(32'h4A4AF7BC, 4'b0011, 1'b1);
    rst = 1'b1;
    beat(32'h4A4A4A4A, 4'b0000, 1'b1);
    rst = 1'b0;
    chk("mid_rst_locked", {31'b0, locked}, 32'h0);
    chk("mid_rst_data", data_out, 32'h0);
    beat(32'h17FF1CBC, 4'b0011, 1'b1);
    chk("post_rst", data_out, 32'h00001CBC);

    for (int n = 0; n < 1500; n++) begin
      logic [31:0] d;
      logic [3:0]  k;
      int rr;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0:       width = 6'd8;
            1:       width = 6'd16;
            default: width = 6'd32;
          endcase
        end
        beat($urandom, 4'($urandom), 1'b0);
      end else begin
        for (int b = 0; b < 4; b++) begin
          rr = $urandom_range(0, 99);
          k[b] = 1'b1;
          if (rr < 7)       d[8*b +: 8] = 8'hBC;
          else if (rr < 13) d[8*b +: 8] = 8'h1C;
          else if (rr < 17) d[8*b +: 8] = 8'hF7;
          else if (rr < 19) d[8*b +: 8] = 8'h3C;
          else if (rr < 21) d[8*b +: 8] = 8'h7C;
          else begin
            d[8*b +: 8] = 8'($urandom);
            k[b] = 1'b0;
          end
        end
        if ($urandom_range(0, 63) == 0) dis = ~dis;
        rst = ($urandom_range(0, 299) == 0);
        beat(d, k, 1'b1);
        rst = 1'b0;
      end
    end

    beat(32'h0, 4'b0000, 1'b0);
    beat(32'h0, 4'b0000, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
